// File: rtl/muldiv_unit_if.sv
// Command/result bundle between the execution stage and muldiv_unit.
//   master: drives stall, flush, start, op, rs, rt; observes results/status
//   slave : the muldiv unit itself
// Signals:
//   stall      external pipeline stall, gates command acceptance only
//   flush      abort any in-flight op, drop same-cycle command
//   start/op   command valid and opcode (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   rs/rt      operands
//   hi/lo      architectural HI/LO registers
//   busy       operation in flight
//   stall_req  hold the pipeline (acceptance cycle and while busy)
//   done       one-cycle pulse when a mul/div updates HI/LO
//   div_zero   one-cycle pulse with done for a divide by zero
interface muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  stall;
   logic                  flush;
   logic                  start;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] rs;
   logic [DATA_WIDTH-1:0] rt;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;
   logic                  busy;
   logic                  stall_req;
   logic                  done;
   logic                  div_zero;

   modport master (
      output stall, flush, start, op, rs, rt,
      input  hi, lo, busy, stall_req, done, div_zero
   );

   modport slave (
      input  stall, flush, start, op, rs, rt,
      output hi, lo, busy, stall_req, done, div_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, one result bit per cycle.
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave (command in, HI/LO and status out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; MTHI/MTLO complete here in one edge
// PREP  | take magnitudes, record result signs, catch divide by zero
// ITER  | one shift-add (mul) or restoring-subtract (div) step per cycle
// FIX   | apply result signs, write HI/LO, pulse done
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_hi;
   logic [W-1:0]    r_lo;
   logic [2*W-1:0]  r_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_is_div;
   logic            r_signed;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_done;
   logic            r_div_zero;

   logic            w_idle;
   logic            w_arith_op;
   logic [W-1:0]    w_abs_a;
   logic [W-1:0]    w_abs_b;
   logic [W:0]      w_sum;
   logic [2*W-1:0]  w_mul_next;
   logic [W:0]      w_rem_sh;
   logic [W:0]      w_diff;
   logic [2*W-1:0]  w_div_next;
   logic [2*W-1:0]  w_prod;
   logic [W-1:0]    w_quo;
   logic [W-1:0]    w_rem;

   assign w_idle     = (r_state == S_IDLE);
   assign w_arith_op = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);

   // Magnitudes; the most negative value maps onto itself, which read as
   // unsigned is exactly its magnitude, so MIN needs no special case.
   assign w_abs_a = (r_signed && r_a[W-1]) ? -r_a : r_a;
   assign w_abs_b = (r_signed && r_b[W-1]) ? -r_b : r_b;

   // Multiply: multiplier sits in the low half and shifts out LSB first,
   // partial product accumulates in the high half (with carry bit).
   assign w_sum      = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_mul_next = {w_sum, r_acc[W-1:1]};

   // Divide: remainder in the high half, dividend shifting in from the low
   // half while quotient bits fill in behind it.
   assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
   assign w_diff     = w_rem_sh - {1'b0, r_b};
   assign w_div_next = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                                 : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_signed   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         if (bus.flush) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start && !bus.stall) begin
                     case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                           r_a      <= bus.rs;
                           r_b      <= bus.rt;
                           r_is_div <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                           r_signed <= (bus.op == OP_MULT) || (bus.op == OP_DIV);
                           r_state  <= S_PREP;
                        end
                        OP_MTHI: r_hi <= bus.rs;
                        OP_MTLO: r_lo <= bus.rs;
                        default: ;
                     endcase
                  end
               end
               S_PREP: begin
                  if (r_is_div && (r_b == '0)) begin
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_b     <= w_abs_b;
                     r_neg_q <= r_signed && (r_a[W-1] ^ r_b[W-1]);
                     r_neg_r <= r_signed && r_a[W-1];
                     r_acc   <= {{W{1'b0}}, w_abs_a};
                     r_cnt   <= CW'(W - 1);
                     r_state <= S_ITER;
                  end
               end
               S_ITER: begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  if (r_cnt == '0) begin
                     r_state <= S_FIX;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               S_FIX: begin
                  if (r_is_div) begin
                     r_lo <= w_quo;
                     r_hi <= w_rem;
                  end else begin
                     r_lo <= w_prod[W-1:0];
                     r_hi <= w_prod[2*W-1:W];
                  end
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;
   assign bus.busy      = !w_idle;
   assign bus.done      = r_done;
   assign bus.div_zero  = r_div_zero;
   assign bus.stall_req = !w_idle || (bus.start && !bus.stall && w_idle && w_arith_op);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit and an 8-bit instance, with a
// reference model feeding a scoreboard queue of expected HI/LO results.
module tb_muldiv_unit;
   logic clk;
   logic rst_n;

   muldiv_unit_if #(.DATA_WIDTH(32)) b32 ();
   muldiv_unit_if #(.DATA_WIDTH(8))  b8 ();

   muldiv_unit #(.DATA_WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   muldiv_unit #(.DATA_WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [7:0]  m_hi8 = '0;
   logic [7:0]  m_lo8 = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one mul/div on the 32-bit unit and check latency, handshake and result.
   task automatic do_op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] p;
      int cyc;
      bit seen, sr_ok;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      e.dz = 1'b0;
      e.lat = 35;
      e.hi = m_hi;
      e.lo = m_lo;
      case (op)
         3'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd2: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         3'd3, 3'd4: begin
            if (b == 0) begin
               e.dz = 1'b1;
               e.lat = 2;
            end else if (op == 3'd3) begin
               q = sa / sb;
               r = sa % sb;
               e.lo = q[31:0];
               e.hi = r[31:0];
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
         default: ;
      endcase
      m_hi = e.hi;
      m_lo = e.lo;
      sbq.push_back(e);

      @(negedge clk);
      b32.start = 1'b1;
      b32.op = op;
      b32.rs = a;
      b32.rt = b;
      #1 chk("stall_req_accept", b32.stall_req, 1'b1);
      @(posedge clk);
      #1;
      b32.start = 1'b0;
      b32.rs = $urandom;
      b32.rt = $urandom;
      cyc = 0;
      seen = 1'b0;
      sr_ok = 1'b1;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (b32.done) seen = 1'b1;
         else if (!b32.stall_req || !b32.busy) sr_ok = 1'b0;
      end
      chk("done_seen", seen, 1'b1);
      e = sbq.pop_front();
      chk("latency", cyc, e.lat);
      chk("stall_req_held", sr_ok, 1'b1);
      chk("stall_req_at_done", b32.stall_req, 1'b0);
      chk("hi", b32.hi, e.hi);
      chk("lo", b32.lo, e.lo);
      chk("div_zero", b32.div_zero, e.dz);
      @(negedge clk);
      chk("done_one_cycle", b32.done, 1'b0);
      chk("busy_after", b32.busy, 1'b0);
   endtask

   task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      logic signed [15:0] sa, sb, q, r;
      logic [15:0] p;
      int cyc;
      bit seen;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      e.dz = 1'b0;
      e.lat = 11;
      e.hi = {24'b0, m_hi8};
      e.lo = {24'b0, m_lo8};
      case (op)
         3'd1: begin p = sa * sb; e.hi = {24'b0, p[15:8]}; e.lo = {24'b0, p[7:0]}; end
         3'd3: begin
            q = sa / sb;
            r = sa % sb;
            e.lo = {24'b0, q[7:0]};
            e.hi = {24'b0, r[7:0]};
         end
         default: ;
      endcase
      m_hi8 = e.hi[7:0];
      m_lo8 = e.lo[7:0];
      sbq.push_back(e);

      @(negedge clk);
      b8.start = 1'b1;
      b8.op = op;
      b8.rs = a;
      b8.rt = b;
      @(posedge clk);
      #1;
      b8.start = 1'b0;
      b8.rs = 8'($urandom);
      b8.rt = 8'($urandom);
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (b8.done) seen = 1'b1;
      end
      e = sbq.pop_front();
      chk("w8_done_seen", seen, 1'b1);
      chk("w8_latency", cyc, e.lat);
      chk("w8_hi", b8.hi, e.hi);
      chk("w8_lo", b8.lo, e.lo);
   endtask

   initial begin
      int  cyc;
      bit  saw_done;
      rst_n = 1'b0;
      b32.stall = 1'b0; b32.flush = 1'b0; b32.start = 1'b0; b32.op = '0; b32.rs = '0; b32.rt = '0;
      b8.stall  = 1'b0; b8.flush  = 1'b0; b8.start  = 1'b0; b8.op  = '0; b8.rs  = '0; b8.rt  = '0;
      repeat (3) @(negedge clk);
      chk("rst_hi", b32.hi, 32'h0);
      chk("rst_lo", b32.lo, 32'h0);
      chk("rst_busy", b32.busy, 1'b0);
      chk("rst_done", b32.done, 1'b0);
      chk("rst_div_zero", b32.div_zero, 1'b0);
      chk("rst_stall_req", b32.stall_req, 1'b0);
      rst_n = 1'b1;

      do_op32(3'd1, 32'hFFFFFFFD, 32'd7);
      chk("mult_neg3x7_hi", b32.hi, 32'hFFFFFFFF);
      chk("mult_neg3x7_lo", b32.lo, 32'hFFFFFFEB);
      do_op32(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      do_op32(3'd4, 32'd100, 32'd7);
      chk("divu_100_7_lo", b32.lo, 32'h0000000E);
      do_op32(3'd3, 32'hFFFFFFF9, 32'd2);
      do_op32(3'd3, 32'h80000000, 32'hFFFFFFFF);
      chk("div_min_m1_lo", b32.lo, 32'h80000000);
      do_op32(3'd4, 32'd5, 32'd0);
      do_op32(3'd3, 32'h12345678, 32'h0);
      do_op32(3'd3, 32'd17, 32'hFFFFFFFB);
      do_op32(3'd1, 32'h80000000, 32'h80000000);
      for (int i = 0; i < 4; i++) begin
         do_op32(3'($urandom_range(1, 4)), $urandom, $urandom);
      end

      // flush mid-operation
      @(negedge clk);
      b32.start = 1'b1; b32.op = 3'd1; b32.rs = 32'd3; b32.rt = 32'd5;
      @(posedge clk);
      #1 b32.start = 1'b0;
      repeat (10) @(negedge clk);
      b32.flush = 1'b1;
      @(negedge clk);
      b32.flush = 1'b0;
      chk("flush_busy", b32.busy, 1'b0);
      chk("flush_hi", b32.hi, m_hi);
      chk("flush_lo", b32.lo, m_lo);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b32.done || b32.busy) saw_done = 1'b1;
      end
      chk("flush_no_done", saw_done, 1'b0);

      // flush drops a same-cycle MTHI
      b32.start = 1'b1; b32.op = 3'd5; b32.rs = 32'hBAD0BAD0; b32.flush = 1'b1;
      @(negedge clk);
      b32.start = 1'b0; b32.flush = 1'b0;
      chk("flush_mthi_ignored", b32.hi, m_hi);

      // MTLO blocked by stall, then accepted
      b32.start = 1'b1; b32.op = 3'd6; b32.rs = 32'h1234; b32.stall = 1'b1;
      #1 chk("mtlo_stall_req", b32.stall_req, 1'b0);
      @(negedge clk);
      chk("mtlo_stalled", b32.lo, m_lo);
      b32.stall = 1'b0;
      @(negedge clk);
      b32.start = 1'b0;
      m_lo = 32'h1234;
      chk("mtlo_lo", b32.lo, m_lo);
      chk("mtlo_no_done", b32.done, 1'b0);

      b32.start = 1'b1; b32.op = 3'd5; b32.rs = 32'hCAFEF00D;
      @(negedge clk);
      b32.start = 1'b0;
      m_hi = 32'hCAFEF00D;
      chk("mthi_hi", b32.hi, m_hi);
      chk("mthi_lo_kept", b32.lo, m_lo);

      // reserved opcode does nothing
      b32.start = 1'b1; b32.op = 3'd7; b32.rs = 32'h5555;
      #1 chk("op7_stall_req", b32.stall_req, 1'b0);
      @(negedge clk);
      b32.start = 1'b0;
      chk("op7_busy", b32.busy, 1'b0);
      chk("op7_hi", b32.hi, m_hi);

      // narrow build
      do_op8(3'd1, 8'h80, 8'h80);
      chk("w8_mult_hi", b8.hi, 8'h40);
      do_op8(3'd3, 8'h81, 8'h05);
      do_op8(3'd1, 8'h7F, 8'hFF);

      // async reset mid-ITER
      @(negedge clk);
      b8.start = 1'b1; b8.op = 3'd1; b8.rs = 8'h11; b8.rt = 8'h22;
      @(posedge clk);
      #1 b8.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("w8_busy_before_rst", b8.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("w8_rst_hi", b8.hi, 8'h0);
      chk("w8_rst_lo", b8.lo, 8'h0);
      chk("w8_rst_busy", b8.busy, 1'b0);
      chk("w8_rst_done", b8.done, 1'b0);
      chk("w8_rst_stall_req", b8.stall_req, 1'b0);
      chk("rst32_hi", b32.hi, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      saw_done = 1'b0;
      while (cyc < 15) begin
         @(negedge clk);
         cyc++;
         if (b8.done) saw_done = 1'b1;
      end
      chk("w8_rst_no_done", saw_done, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
